// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst sequencer that owns a 1-cycle-latency synchronous memory port.
// Ports: cmd_* command handshake, wr_* write beat stream, rd_* read beat stream,
//   busy/cmd_err status, mem_* memory port.
// Optional MEM_BOUNDS_CHECK_EN: reject commands whose start address is >= DEPTH.
module mem_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              cmd_err,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_left;
    logic              r_infl;
    logic              r_infl_last;
    logic [DATA_W-1:0] r_buf_d [2];
    logic [1:0]        r_buf_l;
    logic              r_rp;
    logic              r_wp;
    logic [1:0]        r_cnt;

    logic              w_accept;
    logic              w_oob;
    logic              w_go;
    logic              w_wbeat;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic [ADDR_W-1:0] w_start;
    logic [ADDR_W-1:0] w_cur_inc;

    assign w_start   = ADDR_W'(32'(cmd_addr) % DEPTH);
    assign w_cur_inc = (r_cur == LAST_A) ? '0 : r_cur + 1'b1;
    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_go      = w_accept && !w_oob;
    assign w_wbeat   = (r_state == S_WRITE) && wr_valid;
    assign w_pop     = (r_cnt != 2'd0) && rd_ready;

    // A beat popped this cycle frees its slot in time for the
    // issue made now, which keeps reads at one beat per cycle.
    assign w_occ   = 3'(r_cnt) + 3'(r_infl) - 3'(w_pop);
    assign w_issue = (r_state == S_READ) && (w_occ < 3'd2);

`ifdef MEM_BOUNDS_CHECK_EN
    logic r_err;

    assign w_oob   = 32'(cmd_addr) >= 32'(DEPTH);
    assign cmd_err = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_oob;
        end
    end
`else
    assign w_oob   = 1'b0;
    assign cmd_err = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b1;
        mem_rw    = w_wbeat;
        mem_wdata = w_wbeat ? wr_data : '0;
        mem_addr  = r_cur;
        rd_valid  = r_cnt != 2'd0;
        rd_data   = r_buf_d[r_rp];
        rd_last   = (r_cnt != 2'd0) && r_buf_l[r_rp];
        unique case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_go)
                    w_next = cmd_write ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                if (w_wbeat && r_left == '0)
                    w_next = S_IDLE;
            end
            S_READ: begin
                if (w_issue && r_left == '0)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_infl && (r_cnt == 2'd0 ||
                    (r_cnt == 2'd1 && w_pop)))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_left      <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_buf_d[0]  <= '0;
            r_buf_d[1]  <= '0;
            r_buf_l     <= '0;
            r_rp        <= 1'b0;
            r_wp        <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_cur  <= w_start;
                r_left <= cmd_len;
            end else if (w_wbeat || w_issue) begin
                r_cur <= w_cur_inc;
                if (r_left != '0)
                    r_left <= r_left - 1'b1;
            end
            // Memory answers one cycle after the address.
            r_infl      <= w_issue;
            r_infl_last <= w_issue && (r_left == '0);
            if (r_infl) begin
                r_buf_d[r_wp] <= mem_rdata;
                r_buf_l[r_wp] <= r_infl_last;
                r_wp          <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(r_infl) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: table of bursts against a behavioural memory,
// scoreboard queues for write beats and read beats, plus corner sequences.
module tb_mem_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [4:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       cmd_err;
    logic [7:0] mem_wdata;
    logic [4:0] mem_addr;
    logic       mem_rw;
    logic [7:0] mem_rdata;

    always #5 clk = ~clk;

    mem_burst_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        bit         wr;
        logic [4:0] addr;
        logic [4:0] len;
        logic [7:0] base;
        int         gap;
        int         rmode;
        int         exp_last;
        int         exp_beats;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         last;
    } exp_t;

    exp_t       wq[$];
    exp_t       rq[$];
    exp_t       em;
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    vec_t       tbl [11];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int rmode = 0;
    int w_cnt = 0;
    int w_first = 0;
    int w_last = 0;
    logic [4:0] w_last_a = '0;
    int rd_cnt = 0;
    int r_first = 0;
    int r_last = 0;

    // Synchronous memory: write on rw, registered read.
    always @(posedge clk) begin
        if (mem_rw)
            mem[mem_addr[3:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[3:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: rd_ready = 1'b1;
                1: rd_ready = ~rd_ready;
                2: rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rw) begin
                if (wq.size() == 0) begin
                    fail("spurious_wr");
                end else begin
                    em = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(em.a));
                    chk("wr_data", 32'(mem_wdata), 32'(em.d));
                end
                if (w_cnt == 0)
                    w_first = cyc;
                w_last   = cyc;
                w_last_a = mem_addr;
                w_cnt++;
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    fail("spurious_rd");
                end else begin
                    em = rq.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(em.d));
                    chk("rd_last", 32'(rd_last), 32'(em.last));
                end
                if (rd_cnt == 0)
                    r_first = cyc;
                r_last = cyc;
                rd_cnt++;
            end
`ifndef MEM_BOUNDS_CHECK_EN
            if (cmd_err)
                fail("cmd_err_high");
`endif
        end
    end

    task automatic send_cmd(bit w, logic [4:0] a, logic [4:0] l);
        int k = 0;
        while (!cmd_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(int budget, string nm);
        int k = 0;
        while ((busy || rq.size() != 0 || wq.size() != 0)
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done"},
            32'(busy || rq.size() != 0 || wq.size() != 0), 0);
    endtask

    task automatic run_vec(vec_t v);
        int   a;
        int   k;
        exp_t e;
        a = int'(v.addr) % 16;
        if (v.wr) begin
            w_cnt = 0;
            for (int i = 0; i <= int'(v.len); i++) begin
                e.a  = 8'((a + i) % 16);
                e.d  = v.base + 8'(i);
                e.last = (i == int'(v.len));
                wq.push_back(e);
                ref_mem[(a + i) % 16] = e.d;
            end
            send_cmd(1'b1, v.addr, v.len);
            for (int i = 0; i <= int'(v.len); i++) begin
                if (i > 0) begin
                    wr_valid = 1'b0;
                    repeat (v.gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
                wr_valid = 1'b1;
                wr_data  = v.base + 8'(i);
                k = 0;
                while (!wr_ready && k < 20) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                @(posedge clk);
                #1;
            end
            wr_valid = 1'b0;
            wait_idle(200, "wr");
            chk("wr_beats", 32'(w_cnt), 32'(v.exp_beats));
            chk("wr_last_addr", 32'(w_last_a), 32'(v.exp_last));
            chk("wr_span", 32'(w_last - w_first),
                32'(int'(v.len) * (v.gap + 1)));
        end else begin
            rmode  = v.rmode;
            rd_cnt = 0;
            for (int i = 0; i <= int'(v.len); i++) begin
                e.a    = 8'((a + i) % 16);
                e.d    = ref_mem[(a + i) % 16];
                e.last = (i == int'(v.len));
                rq.push_back(e);
            end
            send_cmd(1'b0, v.addr, v.len);
            wait_idle(400, "rd");
            chk("rd_beats", 32'(rd_cnt), 32'(v.exp_beats));
            if (v.rmode == 0)
                chk("rd_span", 32'(r_last - r_first), 32'(v.len));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_last", 32'(rd_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_err", 32'(cmd_err), 0);
        chk("rst_mem_rw", 32'(mem_rw), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        exp_t e;
        tbl[0]  = '{1'b1, 5'd0,  5'd15, 8'h10, 0, 0, 15, 16};
        tbl[1]  = '{1'b1, 5'd3,  5'd3,  8'hA0, 0, 0, 6,  4};
        tbl[2]  = '{1'b0, 5'd3,  5'd3,  8'h00, 0, 0, 0,  4};
        tbl[3]  = '{1'b1, 5'd14, 5'd3,  8'hB0, 0, 0, 1,  4};
        tbl[4]  = '{1'b0, 5'd14, 5'd3,  8'h00, 0, 0, 0,  4};
        tbl[5]  = '{1'b1, 5'd8,  5'd7,  8'h40, 2, 0, 15, 8};
        tbl[6]  = '{1'b0, 5'd8,  5'd7,  8'h00, 0, 1, 0,  8};
        tbl[7]  = '{1'b0, 5'd0,  5'd31, 8'h00, 0, 2, 0,  32};
        tbl[8]  = '{1'b0, 5'd15, 5'd0,  8'h00, 0, 0, 0,  1};
        tbl[9]  = '{1'b1, 5'd5,  5'd1,  8'hC5, 1, 0, 6,  2};
        tbl[10] = '{1'b0, 5'd4,  5'd3,  8'h00, 0, 1, 0,  4};

        #2;
        reset = 1'b1;
        #1;
        chk_reset_outs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_vec(tbl[i]);

        // First read beat appears on the third cycle after accept.
        rmode  = 0;
        rd_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        e.a = 8'd3;
        e.d = ref_mem[3];
        e.last = 1'b1;
        rq.push_back(e);
        send_cmd(1'b0, 5'd3, 5'd0);
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            k++;
            if (rd_valid)
                break;
        end
        chk("rd_latency", 32'(k), 3);
        wait_idle(50, "lat");
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a stalled read burst.
        rmode = 3;
        repeat (2) @(posedge clk);
        #1;
        send_cmd(1'b0, 5'd0, 5'd7);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_rd_valid", 32'(rd_valid), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outs();
        @(posedge clk);
        #1;
        chk("in_rst_mem_rw", 32'(mem_rw), 0);
        reset = 1'b0;
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        run_vec('{1'b1, 5'd2, 5'd1, 8'hE0, 0, 0, 3, 2});
        run_vec('{1'b0, 5'd2, 5'd1, 8'h00, 0, 0, 0, 2});

`ifdef MEM_BOUNDS_CHECK_EN
        send_cmd(1'b1, 5'd20, 5'd0);
        chk("oob_cmd_err", 32'(cmd_err), 1);
        chk("oob_busy", 32'(busy), 0);
        chk("oob_mem_rw", 32'(mem_rw), 0);
        @(posedge clk);
        #1;
        chk("oob_err_pulse", 32'(cmd_err), 0);
        chk("oob_busy2", 32'(busy), 0);
        chk("oob_ready", 32'(cmd_ready), 1);
`else
        run_vec('{1'b1, 5'd20, 5'd0, 8'h77, 0, 0, 4, 1});
        run_vec('{1'b0, 5'd4, 5'd0, 8'h00, 0, 0, 0, 1});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
